// File: rtl/clint_pkg.sv
// Shared types, register offsets and byte-lane helper for the wb_clint core-local interruptor.
package clint_pkg;

    typedef logic [63:0] mtime_t;

    localparam logic [31:0] MSIP_OFF        = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_LO_OFF = 32'h0000_4000;
    localparam logic [31:0] MTIMECMP_HI_OFF = 32'h0000_4004;
    localparam logic [31:0] MTIME_LO_OFF    = 32'h0000_BFF8;
    localparam logic [31:0] MTIME_HI_OFF    = 32'h0000_BFFC;

    localparam mtime_t MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_mtime.sv
// Free-running 64-bit mtime with prescaler; a bus write to either half wins over that cycle's increment.
module clint_mtime
    import clint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [3:0]  sel,
    input  logic [31:0] wdat,
    output mtime_t      mtime
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] pre_q, pre_d;
    mtime_t        mtime_q, mtime_d;
    logic          inc;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        inc     = (pre_q == CW'(PRESCALE - 1));
        pre_d   = inc ? '0 : pre_q + 1'b1;
        mtime_d = mtime_q;
        if (wr_lo || wr_hi) begin
            // The whole increment is dropped, so no carry crosses into the unwritten half.
            if (wr_lo) mtime_d[31:0]  = merge_bytes(mtime_q[31:0],  wdat, sel);
            if (wr_hi) mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdat, sel);
        end else if (inc) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            mtime_q <= '0;
        end else begin
            pre_q   <= pre_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime = mtime_q;

endmodule

// File: rtl/wb_clint.sv
// Wishbone B4 pipelined CLINT slave: msip, mtimecmp, mtime and the timer/software interrupt levels.
// Define CLINT_MTIME_LATCH_EN to latch mtime[63:32] on every mtime[31:0] read for coherent lo-then-hi reads.
module wb_clint
    import clint_pkg::*;
#(
    parameter int ADR_WIDTH = 16,
    parameter int PRESCALE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [ADR_WIDTH-1:0] adr_i,
    input  logic [3:0]           sel_i,
    input  logic [31:0]          dat_i,
    output logic [31:0]          dat_o,
    output logic                 ack_o,
    output logic                 stall_o,
    output logic                 timer_int,
    output logic                 software_int
);

    logic [31:0] off;
    logic        req, wr, rd;
    logic        hit_msip, hit_cmp_lo, hit_cmp_hi, hit_mt_lo, hit_mt_hi;
    mtime_t      mtime, mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d, ack_q, ack_d, timer_q, timer_d, sw_q, sw_d;
    logic [31:0] dat_q, dat_d, rdata, mtime_hi_rd;

    always_comb begin
        off        = 32'(adr_i) & ~32'h3;
        req        = cyc_i & stb_i;
        wr         = req & we_i;
        rd         = req & ~we_i;
        hit_msip   = (off == MSIP_OFF);
        hit_cmp_lo = (off == MTIMECMP_LO_OFF);
        hit_cmp_hi = (off == MTIMECMP_HI_OFF);
        hit_mt_lo  = (off == MTIME_LO_OFF);
        hit_mt_hi  = (off == MTIME_HI_OFF);
    end

    clint_mtime #(.PRESCALE(PRESCALE)) u_mtime (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_lo (wr & hit_mt_lo),
        .wr_hi (wr & hit_mt_hi),
        .sel   (sel_i),
        .wdat  (dat_i),
        .mtime (mtime)
    );

`ifdef CLINT_MTIME_LATCH_EN
    logic [31:0] shadow_q, shadow_d;

    always_comb shadow_d = (rd && hit_mt_lo) ? mtime[63:32] : shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_q <= '0;
        else        shadow_q <= shadow_d;
    end

    assign mtime_hi_rd = shadow_q;
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        dat_d      = dat_q;
        rdata      = '0;
        if (hit_msip)        rdata = {31'b0, msip_q};
        else if (hit_cmp_lo) rdata = mtimecmp_q[31:0];
        else if (hit_cmp_hi) rdata = mtimecmp_q[63:32];
        else if (hit_mt_lo)  rdata = mtime[31:0];
        else if (hit_mt_hi)  rdata = mtime_hi_rd;

        if (wr && hit_msip && sel_i[0]) msip_d = dat_i[0];
        if (wr && hit_cmp_lo) mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  dat_i, sel_i);
        if (wr && hit_cmp_hi) mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], dat_i, sel_i);
        if (rd) dat_d = rdata;

        ack_d   = req;
        timer_d = (mtime >= mtimecmp_q);
        sw_d    = msip_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip_q     <= 1'b0;
            mtimecmp_q <= MTIMECMP_RST;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            timer_q    <= 1'b0;
            sw_q       <= 1'b0;
        end else begin
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            timer_q    <= timer_d;
            sw_q       <= sw_d;
        end
    end

    // Dropping cyc_i kills an ack still in flight; the write itself already landed.
    assign ack_o        = ack_q & cyc_i;
    assign dat_o        = dat_q;
    assign stall_o      = 1'b0;
    assign timer_int    = timer_q;
    assign software_int = sw_q;

endmodule

// File: tb/tb_wb_clint.sv
// Self-checking bench for wb_clint: directed scenarios plus random bus traffic against a time-based model.
`timescale 1ns/1ps
module tb_wb_clint;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [15:0] adr_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        ack_o, stall_o, timer_int, software_int;

    wb_clint #(.ADR_WIDTH(16), .PRESCALE(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cyc_i        (cyc_i),
        .stb_i        (stb_i),
        .we_i         (we_i),
        .adr_i        (adr_i),
        .sel_i        (sel_i),
        .dat_i        (dat_i),
        .dat_o        (dat_o),
        .ack_o        (ack_o),
        .stall_o      (stall_o),
        .timer_int    (timer_int),
        .software_int (software_int)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mtime is an anchor value plus elapsed clock edges since it was last written.
    logic [63:0] mt_base;
    int          mt_base_n;
    int          n_edges;
    logic [63:0] cmp_m;
    logic        msip_m;
    logic [31:0] shadow_m, last_rd_m;
    logic        exp_t, exp_s;
    bit          chk_int = 1'b0;
    bit          pend = 1'b0;
    logic [15:0] pend_adr;
    logic [3:0]  pend_sel;
    logic [31:0] pend_dat;
    logic [31:0] rv;

    function automatic logic [63:0] mt_now();
        return mt_base + 64'(n_edges - mt_base_n);
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        logic [63:0] m;
        m = mt_now();
        case (a & 16'hFFFC)
            16'h0000: return {31'b0, msip_m};
            16'h4000: return cmp_m[31:0];
            16'h4004: return cmp_m[63:32];
            16'hBFF8: return m[31:0];
`ifdef CLINT_MTIME_LATCH_EN
            16'hBFFC: return shadow_m;
`else
            16'hBFFC: return m[63:32];
`endif
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        mt_base   = '0;
        mt_base_n = 0;
        n_edges   = 0;
        cmp_m     = 64'hFFFF_FFFF_FFFF_FFFF;
        msip_m    = 1'b0;
        shadow_m  = '0;
        last_rd_m = '0;
        pend      = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: interrupt levels seen after the edge come from model state held before it.
    task automatic tick();
        logic [63:0] prev;
        exp_t = (mt_now() >= cmp_m);
        exp_s = msip_m;
        @(posedge clk);
        if (pend) begin
            prev = mt_now();
            case (pend_adr & 16'hFFFC)
                16'h0000: if (pend_sel[0]) msip_m = pend_dat[0];
                16'h4000: cmp_m[31:0]  = lanes(cmp_m[31:0],  pend_dat, pend_sel);
                16'h4004: cmp_m[63:32] = lanes(cmp_m[63:32], pend_dat, pend_sel);
                16'hBFF8: begin
                    mt_base   = {prev[63:32], lanes(prev[31:0], pend_dat, pend_sel)};
                    mt_base_n = n_edges + 1;
                end
                16'hBFFC: begin
                    mt_base   = {lanes(prev[63:32], pend_dat, pend_sel), prev[31:0]};
                    mt_base_n = n_edges + 1;
                end
                default: ;
            endcase
        end
        pend = 1'b0;
        n_edges++;
        #1;
        if (chk_int) begin
            check("timer_int", 64'(timer_int), 64'(exp_t));
            check("software_int", 64'(software_int), 64'(exp_s));
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
        adr_i = a; sel_i = s; dat_i = d;
        pend = 1'b1; pend_adr = a; pend_sel = s; pend_dat = d;
        tick();
        check($sformatf("wr_ack %h", a), 64'(ack_o), 64'd1);
        check("wr_dat_hold", 64'(dat_o), 64'(last_rd_m));
        check("stall", 64'(stall_o), 64'd0);
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] v);
        logic [31:0] exp;
        exp = model_read(a);
        if ((a & 16'hFFFC) == 16'hBFF8) shadow_m = mt_now() >> 32;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
        adr_i = a; sel_i = 4'hF;
        tick();
        check($sformatf("rd_ack %h", a), 64'(ack_o), 64'd1);
        check($sformatf("rd_dat %h", a), 64'(dat_o), 64'(exp));
        check("stall", 64'(stall_o), 64'd0);
        last_rd_m = exp;
        v = dat_o;
    endtask

    task automatic bus_idle();
        stb_i = 1'b0; we_i = 1'b0;
        tick();
        check("idle_ack", 64'(ack_o), 64'd0);
        cyc_i = 1'b0;
    endtask

    initial begin
        model_reset();
        #20;
        check("rst dat_o", 64'(dat_o), 64'd0);
        check("rst ack_o", 64'(ack_o), 64'd0);
        check("rst stall_o", 64'(stall_o), 64'd0);
        check("rst timer_int", 64'(timer_int), 64'd0);
        check("rst software_int", 64'(software_int), 64'd0);
        #3;
        rst_n = 1'b1;
        model_reset();
        chk_int = 1'b1;

        // mtime counts every edge after reset release.
        repeat (10) tick();
        bus_rd(16'hBFF8, rv);
        check("mtime after 10", 64'(rv), 64'd10);
        bus_idle();

        // Software interrupt set and clear.
        bus_wr(16'h0000, 4'b0001, 32'h1);
        bus_idle();
        check("sw set", 64'(software_int), 64'd1);
        bus_wr(16'h0000, 4'b0001, 32'h0);
        bus_idle();
        check("sw clear", 64'(software_int), 64'd0);

        // Timer compare at 0x40.
        bus_wr(16'hBFFC, 4'hF, 32'h0);
        bus_wr(16'hBFF8, 4'hF, 32'h0);
        bus_wr(16'h4004, 4'hF, 32'h0);
        bus_wr(16'h4000, 4'hF, 32'h40);
        bus_idle();
        repeat (80) tick();
        check("timer fired", 64'(timer_int), 64'd1);
        bus_wr(16'h4000, 4'hF, 32'hFFFF_FFFF);
        bus_idle();
        check("timer cleared", 64'(timer_int), 64'd0);

        // Carry from lo into hi; a write in an increment cycle is kept exactly.
        bus_wr(16'hBFFC, 4'hF, 32'h0);
        bus_wr(16'hBFF8, 4'hF, 32'hFFFF_FFFE);
        bus_idle();
        repeat (3) tick();
        bus_rd(16'hBFFC, rv);
        check("mtime carry", 64'(rv), 64'd1);
        bus_wr(16'hBFF8, 4'hF, 32'h1234_5678);
        bus_rd(16'hBFF8, rv);
        check("mtime write exact", 64'(rv), 64'h1234_5678);
        bus_idle();

        // Back-to-back pipelined reads.
        bus_wr(16'h4004, 4'hF, 32'hFFFF_FFFF);
        bus_idle();
        bus_rd(16'h4000, rv);
        check("pipe 4000", 64'(rv), 64'hFFFF_FFFF);
        bus_rd(16'h4004, rv);
        check("pipe 4004", 64'(rv), 64'hFFFF_FFFF);
        bus_rd(16'h1234, rv);
        check("pipe 1234", 64'(rv), 64'h0);
        bus_idle();

        // cyc_i dropped in the ack cycle: ack suppressed, write still committed.
        bus_wr(16'h0000, 4'b0001, 32'h1);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        #1;
        check("cyc drop ack", 64'(ack_o), 64'd0);
        tick();
        bus_rd(16'h0000, rv);
        check("cyc drop commit", 64'(rv), 64'd1);
        bus_wr(16'h0000, 4'b1110, 32'h0);
        bus_rd(16'h0000, rv);
        check("msip lane0 unselected", 64'(rv), 64'd1);
        bus_wr(16'h0000, 4'b0001, 32'h0);
        bus_idle();

        // Lo-then-hi read across a carry.
        bus_wr(16'hBFFC, 4'hF, 32'h1);
        bus_wr(16'hBFF8, 4'hF, 32'hFFFF_FFF0);
        bus_idle();
        bus_rd(16'hBFF8, rv);
        bus_idle();
        repeat (32) tick();
        bus_rd(16'hBFFC, rv);
`ifdef CLINT_MTIME_LATCH_EN
        check("latched hi", 64'(rv), 64'd1);
`else
        check("live hi", 64'(rv), 64'd2);
`endif
        bus_idle();

        // Random traffic, sometimes pipelined.
        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            case ($urandom_range(0, 5))
                0:       a = 16'h0000;
                1:       a = 16'h4000;
                2:       a = 16'h4004;
                3:       a = 16'hBFF8;
                4:       a = 16'hBFFC;
                default: a = 16'($urandom);
            endcase
            a = a | 16'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) bus_wr(a, 4'($urandom), $urandom);
            else                           bus_rd(a, rv);
            if ($urandom_range(0, 2) == 0) bus_idle();
        end
        bus_idle();

        // Reset asserted while an ack is out and a write is pending.
        bus_rd(16'h4000, rv);
        we_i = 1'b1; adr_i = 16'h0000; sel_i = 4'hF; dat_i = 32'h1;
        rst_n = 1'b0;
        #1;
        check("rst mid ack", 64'(ack_o), 64'd0);
        check("rst mid dat", 64'(dat_o), 64'd0);
        check("rst mid timer", 64'(timer_int), 64'd0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        chk_int = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        chk_int = 1'b1;
        bus_rd(16'h0000, rv);
        check("msip after rst", 64'(rv), 64'd0);
        bus_rd(16'h4004, rv);
        check("cmp hi after rst", 64'(rv), 64'hFFFF_FFFF);
        bus_rd(16'hBFF8, rv);
        bus_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
